// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
//   md_op_e     : operation select carried on func3 (MUL .. REMU)
//   md_state_e  : control states of the iterative datapath
//   is_signed_a : rs1 is treated as a signed value for this operation
//   is_signed_b : rs2 is treated as a signed value for this operation
//   is_div      : operation uses the divider (DIV, DIVU, REM, REMU)
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic is_signed_a(md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_div(md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   i_valid/o_ready   : request handshake (i_func3, i_A, i_B, i_tag)
//   i_flush           : kill whatever the unit is doing
//   o_valid/i_ready   : result handshake (o_result, o_tag)
//   o_busy            : unit is computing or holding a result
// The slave modport is the unit; the master modport is the pipeline.
interface ex_muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_func3;
    logic [XLEN-1:0]  i_A;
    logic [XLEN-1:0]  i_B;
    logic [TAG_W-1:0] i_tag;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_busy;

    modport slave (
        input  i_valid, i_func3, i_A, i_B, i_tag, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_tag, o_busy
    );

    modport master (
        output i_valid, i_func3, i_A, i_B, i_tag, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_tag, o_busy
    );
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Final result selection for the multiply/divide unit. The iterative
// datapath works on operand magnitudes; this block restores the sign and
// picks the requested half of the product, or the quotient/remainder.
//   op     : operation select
//   neg_a  : rs1 was a negative signed operand
//   neg_b  : rs2 was a negative signed operand
//   raw    : {high, low} product, or {remainder, quotient} for divides
//   result : XLEN-bit architectural result
module ex_muldiv_unit_sign_fix
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  md_op_e              op,
    input  logic                neg_a,
    input  logic                neg_b,
    input  logic [2*XLEN-1:0]   raw,
    output logic [XLEN-1:0]     result
);

    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;

    always_comb begin
        // The remainder follows the dividend's sign; everything else
        // is negated when exactly one operand was negative.
        product   = (neg_a ^ neg_b) ? -raw : raw;
        quotient  = (neg_a ^ neg_b) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        remainder = neg_a ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        result    = '0;
        case (op)
            MD_MUL:                         result = product[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   result = product[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:                result = quotient;
            MD_REM, MD_REMU:                result = remainder;
            default:                        result = '0;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
// One radix-2 datapath is shared: shift-add for multiplies, restoring
// division for divides, one bit per cycle for XLEN cycles. Divide by
// zero and signed overflow are resolved at accept and skip the loop.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : request/result handshake, flush and busy (slave side)
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ex_muldiv_unit_if.slave  bus
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state;
    md_state_e          state_next;
    logic [CNT_W-1:0]   counter;
    md_op_e             op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               neg_a;
    logic               neg_b;
    logic [XLEN-1:0]    operand_b;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  acc_next;
    logic [XLEN-1:0]    result_q;
    logic [TAG_W-1:0]   out_tag_q;

    md_op_e             op_in;
    logic               accept;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [XLEN-1:0]    in_mag_a;
    logic [XLEN-1:0]    in_mag_b;
    logic               div_zero;
    logic               div_ovf;
    logic               special;
    logic [XLEN-1:0]    special_result;

    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      rem_shift;
    logic [XLEN:0]      rem_diff;
    logic               fits;
    logic [XLEN-1:0]    fixed_result;

    assign op_in  = md_op_e'(bus.i_func3);
    assign accept = bus.i_valid && (state == IDLE) && !bus.i_flush;

    // Operand conditioning at accept: sign flags, magnitudes and the
    // two divide corner cases that bypass the iterative loop.
    always_comb begin
        in_neg_a       = is_signed_a(op_in) && bus.i_A[XLEN-1];
        in_neg_b       = is_signed_b(op_in) && bus.i_B[XLEN-1];
        in_mag_a       = in_neg_a ? -bus.i_A : bus.i_A;
        in_mag_b       = in_neg_b ? -bus.i_B : bus.i_B;
        div_zero       = is_div(op_in) && (bus.i_B == '0);
        div_ovf        = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                         (bus.i_A == MOST_NEG) && (bus.i_B == '1);
        special        = div_zero || div_ovf;
        special_result = '0;
        if (div_zero) begin
            special_result = ((op_in == MD_DIV) || (op_in == MD_DIVU)) ? '1 : bus.i_A;
        end else if (div_ovf) begin
            special_result = (op_in == MD_DIV) ? bus.i_A : '0;
        end
    end

    // One iteration of the shared datapath. For multiplies acc holds
    // {partial product, remaining multiplier bits}; for divides it holds
    // {partial remainder, dividend bits / quotient bits}. The shifted
    // remainder needs one extra bit so the trial subtract cannot overflow.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : '0);
        rem_shift = acc[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, operand_b};
        fits      = !rem_diff[XLEN];
        if (is_div(op_q)) begin
            acc_next = {(fits ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                        acc[XLEN-2:0], fits};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    ex_muldiv_unit_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .op     (op_q),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .raw    (acc_next),
        .result (fixed_result)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (counter == LAST) state_next = DONE;
            DONE:    if (bus.i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.i_flush) begin
            state_next = IDLE;
        end
    end

    // Operand capture, iteration and result registration. The result
    // registers only change on entry to DONE, so they stay stable while
    // the consumer applies backpressure.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            counter   <= '0;
            op_q      <= MD_MUL;
            tag_q     <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            operand_b <= '0;
            acc       <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            tag_q     <= bus.i_tag;
            neg_a     <= in_neg_a;
            neg_b     <= in_neg_b;
            operand_b <= in_mag_b;
            acc       <= {{XLEN{1'b0}}, in_mag_a};
            counter   <= '0;
            if (special) begin
                result_q  <= special_result;
                out_tag_q <= bus.i_tag;
            end
        end else if ((state == CALC) && !bus.i_flush) begin
            acc     <= acc_next;
            counter <= counter + 1'b1;
            if (counter == LAST) begin
                result_q  <= fixed_result;
                out_tag_q <= tag_q;
            end
        end
    end

    assign bus.o_ready  = (state == IDLE);
    assign bus.o_valid  = (state == DONE);
    assign bus.o_busy   = (state == CALC) || (state == DONE);
    assign bus.o_result = result_q;
    assign bus.o_tag    = out_tag_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle execute-stage unit implementing the RV32M/RV64M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
It sits beside the single-cycle ALU in the EX stage. The decoder routes funct7=0000001 R-type ops to it, and the pipeline stalls EX while it is busy.
Both multiply and divide use one shared radix-2 shift/add/subtract datapath. A valid/ready handshake is used on both input and output, plus a flush input for branch kills.

Parameters:
XLEN, 32, operand and result width (32 or 64)
TAG_W, 5, width of the destination-register tag carried alongside the operation

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  request valid
o_ready  out  1  unit can accept a request (state IDLE)
i_func3  in  3  operation select; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_A  in  XLEN  rs1 operand
i_B  in  XLEN  rs2 operand
i_tag  in  TAG_W  rd tag, returned unchanged
i_flush  in  1  kill the in-flight operation
o_valid  out  1  result valid
i_ready  in  1  consumer accepts the result
o_result  out  XLEN  result
o_tag  out  TAG_W  tag of the result
o_busy  out  1  high in state CALC or DONE

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0, o_tag=0, iteration counter=0.
  - Reset asserted mid-operation abandons the operation immediately; no result is ever produced for it.
- State machine: IDLE, CALC, DONE.
  - o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE:
  - Accept occurs on a rising edge with i_valid && o_ready && !i_flush.
  - On accept, latch func3, tag, operand magnitudes and sign flags.
    - Signed operands: DIV, REM, MULH (both operands), MULHSU (rs1 only).
  - Special cases go directly to DONE on the next edge (o_valid in cycle 1 after accept):
    - Divide by zero (i_B==0): DIV/DIVU result = all ones; REM/REMU result = i_A.
    - Signed overflow (DIV/REM with i_A = most-negative value and i_B = -1): DIV result = i_A; REM result = 0.
  - Otherwise go to CALC with counter=0.
- CALC:
  - One bit per cycle, exactly XLEN cycles (counter 0..XLEN-1).
  - Multiply: 2*XLEN accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring; shift the partial remainder, trial-subtract the divisor, set the quotient bit.
  - When counter==XLEN-1, the next edge moves to DONE and registers the sign-corrected result:
    - MUL: low XLEN bits of the product.
    - MULH, MULHSU, MULHU: high XLEN bits of the product.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Normal-case latency: accept in cycle 0, o_valid high from cycle XLEN+1.
- DONE:
  - o_result and o_tag are held stable while o_valid && !i_ready.
  - On o_valid && i_ready, go to IDLE.
  - No accept occurs in the same cycle as the result handshake; o_ready rises one cycle later.
- i_flush (synchronous):
  - In any state, the next edge goes to IDLE with o_valid=0; the result is discarded.
  - A flush concurrent with i_valid in IDLE blocks the accept.
  - Flush takes priority over an i_ready handshake in DONE.
- Operand inputs are only sampled at accept; changes during CALC have no effect.
- All arithmetic is modulo 2^XLEN, with no X propagation.
  - The func3 decode is fully specified; there are no undefined outputs.

Decomposition:
- Shared package MulDivPkg holds:
  - a typedef enum for func3 (MD_MUL .. MD_REMU);
  - a typedef enum for the states (IDLE, CALC, DONE);
  - a function is_signed_a/is_signed_b(func3).
- The EX pipeline-register structs gain a muldiv_tag field in the existing PipelineReg package.
- One natural sub-module, muldiv_sign_fix: combinational negation/selection of the final result from the magnitude result, func3 and the sign flags.
- The FSM, counter and iterative datapath stay in ex_muldiv_unit.

Test Plan:
- XLEN=32, MUL A=7 B=-3:
  - o_valid exactly 33 cycles after accept, o_result=0xFFFFFFEB.
  - MULHU A=B=0xFFFFFFFF gives 0xFFFFFFFE; MULHSU A=-1 B=2 gives 0xFFFFFFFF.
- DIV A=-7 B=2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF. DIVU A=0x80000000 B=3 gives 0x2AAAAAAA; REMU gives 2.
- Divide by zero: DIV A=5 B=0 gives 0xFFFFFFFF and REM gives 5, with o_valid one cycle after accept. Overflow: DIV 0x80000000 / -1 gives 0x80000000 and REM gives 0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE. o_result and o_tag stay stable and o_ready=0; when i_ready=1, the unit is in IDLE the next cycle.
- Assert i_flush in CALC cycle 5: the unit is IDLE next cycle and o_valid is never asserted. The next request (MUL 3,4) returns 12 with its own tag.
- Assert i_reset asynchronously mid-CALC (off clock edge): outputs take reset values immediately. Repeat with XLEN=64: MULH A=B=0x8000000000000000 gives 0x4000000000000000, latency 65 cycles.
